// File: rtl/def.sv
// Shared definitions for the execute stage: opcode set, FSM states and an
// opcode classification used by the decode side of the stage.
package def;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_BEQ  = 4'd7,
        OP_BNE  = 4'd8,
        OP_BLT  = 4'd9,
        OP_BGE  = 4'd10,
        OP_JAL  = 4'd11,
        OP_JALR = 4'd12,
        OP_MUL  = 4'd13
    } exec_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } exec_state_t;

    // Instruction class bits derived from the opcode
    typedef struct packed {
        logic branch;
        logic jump;
        logic mul;
    } op_class_t;

    function automatic op_class_t op_class(input exec_op_t op);
        op_class_t c;
        c.branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE);
        c.jump   = (op == OP_JAL) || (op == OP_JALR);
        c.mul    = (op == OP_MUL);
        return c;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low XLEN bits.
// The final step is folded into 'product' so the result is usable on the done edge.
module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            abort,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN);

    logic            active;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] addend;

    assign addend  = mplier[0] ? mcand : '0;
    assign done    = active && (cnt == CW'(XLEN - 1));
    assign product = acc + addend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (abort) begin
            active <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (active) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_mc.sv
// Execute stage: single-cycle ALU/branch/jump ops plus an iterative multiply,
// with a registered, back-pressurable output and a flush that overrides everything.
module exec_mc
    import def::*;
#(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  exec_op_t        op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            is_jump_chosen,
    output logic [XLEN-1:0] next_pc,
    output logic            busy
);
    exec_state_t     state, state_nx;
    op_class_t       cls;
    logic            accept;
    logic            go_mul;
    logic            mul_done;
    logic [XLEN-1:0] product;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] res_c;
    logic            jmp_c;
    logic [XLEN-1:0] npc_c;

    assign cls       = op_class(op);
    assign in_ready  = !flush && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign go_mul    = accept && cls.mul && (MUL_EN != 0);
    assign out_valid = (state == S_HOLD);
    assign busy      = (state == S_MUL);

    // Single-cycle datapath; OP_MUL falls through to 0 when the multiplier is absent
    always_comb begin
        res_c = '0;
        jmp_c = 1'b0;
        npc_c = pc + XLEN'(4);
        case (op)
            OP_ADD:  res_c = rs1 + rs2;
            OP_SUB:  res_c = rs1 - rs2;
            OP_AND:  res_c = rs1 & rs2;
            OP_OR:   res_c = rs1 | rs2;
            OP_XOR:  res_c = rs1 ^ rs2;
            OP_SLT:  res_c = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU: res_c = {{(XLEN-1){1'b0}}, rs1 < rs2};
            OP_BEQ:  jmp_c = (rs1 == rs2);
            OP_BNE:  jmp_c = (rs1 != rs2);
            OP_BLT:  jmp_c = ($signed(rs1) < $signed(rs2));
            OP_BGE:  jmp_c = !($signed(rs1) < $signed(rs2));
            OP_JAL:  npc_c = pc + imm;
            OP_JALR: npc_c = (rs1 + imm) & ~XLEN'(1);
            default: res_c = '0;
        endcase
        if (cls.jump) begin
            jmp_c = 1'b1;
            res_c = pc + XLEN'(4);
        end
        if (cls.branch && jmp_c) npc_c = pc + imm;
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            mul_iter #(.XLEN(XLEN)) u_mul (
                .clk     (clk),
                .rstn    (rstn),
                .start   (go_mul),
                .a       (rs1),
                .b       (rs2),
                .abort   (flush),
                .done    (mul_done),
                .product (product)
            );
        end else begin : g_nomul
            assign mul_done = 1'b0;
            assign product  = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = go_mul ? S_MUL : S_HOLD;
            S_MUL:   if (mul_done) state_nx = S_HOLD;
            S_HOLD:  if (out_ready) state_nx = accept ? (go_mul ? S_MUL : S_HOLD) : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    // Output registers only change on a load, so a stalled result stays intact
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result         <= '0;
            is_jump_chosen <= 1'b0;
            next_pc        <= '0;
            pc_q           <= '0;
        end else if (!flush) begin
            if (go_mul) begin
                pc_q <= pc;
            end else if (accept) begin
                result         <= res_c;
                is_jump_chosen <= jmp_c;
                next_pc        <= npc_c;
            end else if ((state == S_MUL) && mul_done) begin
                result         <= product;
                is_jump_chosen <= 1'b0;
                next_pc        <= pc_q + XLEN'(4);
            end
        end
    end

endmodule

// File: tb/tb_exec_mc.sv
// Directed and randomized bench for exec_mc against an arithmetic reference model.
module tb_exec_mc;
    import def::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    exec_op_t        op = OP_ADD;
    logic [XLEN-1:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            is_jump_chosen;
    logic [XLEN-1:0] next_pc;
    logic            busy;

    int checks = 0;
    int failures = 0;

    exec_mc #(.XLEN(XLEN), .MUL_EN(1)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .pc             (pc),
        .rs1            (rs1),
        .rs2            (rs2),
        .imm            (imm),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .is_jump_chosen (is_jump_chosen),
        .next_pc        (next_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour straight from the instruction semantics
    function automatic void model(input exec_op_t o, input logic [31:0] p, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] i,
                                  output logic [31:0] r, output logic j, output logic [31:0] n);
        r = 32'd0;
        j = 1'b0;
        n = p + 32'd4;
        case (o)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_BEQ:  j = (a == b);
            OP_BNE:  j = (a != b);
            OP_BLT:  j = ($signed(a) < $signed(b));
            OP_BGE:  j = ($signed(a) >= $signed(b));
            OP_JAL:  begin r = p + 32'd4; j = 1'b1; n = p + i; end
            OP_JALR: begin r = p + 32'd4; j = 1'b1; n = (a + i) & 32'hFFFF_FFFE; end
            OP_MUL:  r = a * b;
            default: r = 32'd0;
        endcase
        if ((o == OP_BEQ || o == OP_BNE || o == OP_BLT || o == OP_BGE) && j) n = p + i;
    endfunction

    task automatic issue(input exec_op_t o, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i);
        op = o; pc = p; rs1 = a; rs2 = b; imm = i;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input exec_op_t o, input logic [31:0] p,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
        logic [31:0] r, n;
        logic j;
        model(o, p, a, b, i, r, j, n);
        chk1({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".result"}, result, r);
        chk1({tag, ".jump"}, is_jump_chosen, j);
        chk({tag, ".next_pc"}, next_pc, n);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk1({tag, ".timeout"}, n < 100, 1'b1);
    endtask

    initial begin
        int n, busy_cnt, seen;
        logic [31:0] a, b, p, i;
        exec_op_t ro;

        // Reset state
        #3;
        chk1("rst.valid", out_valid, 1'b0);
        chk1("rst.busy", busy, 1'b0);
        chk("rst.result", result, 32'd0);
        chk1("rst.jump", is_jump_chosen, 1'b0);
        chk("rst.next_pc", next_pc, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk1("rst.in_ready", in_ready, 1'b1);

        // First accept on the first edge after release
        issue(OP_ADD, 32'h0000_0200, 32'd5, 32'd7, 32'd0);
        expect_out("add", OP_ADD, 32'h0000_0200, 32'd5, 32'd7, 32'd0);
        chk("add.const", result, 32'd12);
        tick();
        chk1("add.drain", out_valid, 1'b0);

        issue(OP_BLT, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        expect_out("blt", OP_BLT, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        chk("blt.const", next_pc, 32'h120);
        tick();
        issue(OP_BGE, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        expect_out("bge", OP_BGE, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        chk("bge.const", next_pc, 32'h104);
        tick();
        issue(OP_JALR, 32'h40, 32'h1001, 32'd0, 32'h4);
        expect_out("jalr", OP_JALR, 32'h40, 32'h1001, 32'd0, 32'h4);
        chk("jalr.const_npc", next_pc, 32'h1004);
        chk("jalr.const_res", result, 32'h44);
        tick();

        // Multiply latency and busy window
        issue(OP_MUL, 32'h300, 32'h0000_FFFF, 32'h0001_0001, 32'd0);
        n = 0;
        busy_cnt = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            n++;
        end
        chk("mul.latency", 32'(n), 32'd32);
        chk("mul.busy_cycles", 32'(busy_cnt), 32'd32);
        expect_out("mul", OP_MUL, 32'h300, 32'h0000_FFFF, 32'h0001_0001, 32'd0);
        chk("mul.const", result, 32'hFFFF_FFFF);
        chk1("mul.busy_after", busy, 1'b0);
        tick();

        // Flush in the middle of a multiply
        issue(OP_MUL, 32'h400, 32'd9, 32'd9, 32'd0);
        repeat (9) tick();
        flush = 1'b1;
        op = OP_ADD;
        in_valid = 1'b1;
        #1;
        chk1("flush.in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk1("flush.valid", out_valid, 1'b0);
        chk1("flush.busy", busy, 1'b0);
        chk1("flush.in_ready_after", in_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("flush.no_result", 32'(seen), 32'd0);

        // Back-pressure, then back-to-back accept while draining
        out_ready = 1'b0;
        issue(OP_ADD, 32'h500, 32'd10, 32'd20, 32'd0);
        op = OP_SUB; rs1 = 32'd3; rs2 = 32'd5; pc = 32'h504;
        in_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk1("stall.valid", out_valid, 1'b1);
            chk("stall.result", result, 32'd30);
            chk1("stall.in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk1("b2b.in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1("b2b.valid", out_valid, 1'b1);
        chk("b2b.result", result, 32'hFFFF_FFFE);
        tick();
        chk1("b2b.drain", out_valid, 1'b0);

        // Asynchronous reset mid-multiply
        issue(OP_MUL, 32'h600, 32'd3, 32'd5, 32'd0);
        repeat (5) tick();
        #2 rstn = 1'b0;
        #1;
        chk1("amid.busy", busy, 1'b0);
        chk1("amid.valid", out_valid, 1'b0);
        chk("amid.result", result, 32'd0);
        chk("amid.next_pc", next_pc, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        issue(OP_ADD, 32'h700, 32'd100, 32'd23, 32'd0);
        expect_out("post_rst", OP_ADD, 32'h700, 32'd100, 32'd23, 32'd0);
        tick();

        // Randomized ops with random stall lengths
        for (int t = 0; t < 30; t++) begin
            ro = exec_op_t'(4'($urandom_range(0, 13)));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            p  = $urandom & 32'hFFFF_FFFC;
            i  = $urandom;
            issue(ro, p, a, b, i);
            wait_valid("rnd");
            expect_out("rnd", ro, p, a, b, i);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                tick();
                expect_out("rnd.hold", ro, p, a, b, i);
            end
            out_ready = 1'b1;
            tick();
            chk1("rnd.drain", out_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_mc.md
EXEC_MC -- requirements
Module: exec_mc

Interface
REQ-001 Parameter XLEN, default 32: datapath width for operands, pc, result and next_pc.
REQ-002 Parameter MUL_EN, default 1: 1 enables the iterative multiply path; 0 makes OP_MUL produce result 0 in one cycle.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  issue request.
REQ-006 in_ready  out  1  stage can accept a request.
REQ-007 op  in  4  exec_op_t: ADD, SUB, AND, OR, XOR, SLT, SLTU, BEQ, BNE, BLT, BGE, JAL, JALR, MUL.
REQ-008 pc, rs1, rs2, imm  in  XLEN each  instruction pc, source operands, sign-extended immediate.
REQ-009 flush  in  1  kill any in-flight or held operation.
REQ-010 out_valid  out  1  result registered and held.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 result  out  XLEN  ALU/multiply result; pc+4 for JAL and JALR.
REQ-013 is_jump_chosen  out  1  control transfer taken.
REQ-014 next_pc  out  XLEN  resolved next pc.
REQ-015 busy  out  1  high in S_MUL.

Function
REQ-016 FSM states: S_IDLE, S_MUL, S_HOLD. in_ready SHALL be 1 only in S_IDLE, or in S_HOLD in the cycle out_ready is 1.
REQ-017 Accept: a request is accepted on a rising edge with in_valid && in_ready; operands latch on that edge.
REQ-018 Single-cycle ops: output registers SHALL load on the accepting edge, giving out_valid=1 in the next cycle (latency 1), and the FSM SHALL go to S_HOLD.
REQ-019 Arithmetic: result modulo 2^XLEN; SLT signed, SLTU unsigned, result 0 or 1.
REQ-020 Branches BEQ/BNE/BLT/BGE SHALL compare rs1 with rs2, signed for BLT/BGE. is_jump_chosen = condition; next_pc = pc+imm if taken, otherwise pc+4; result = 0.
REQ-021 JAL: next_pc = pc+imm. JALR: next_pc = (rs1+imm) with bit 0 cleared. For both, is_jump_chosen=1.
REQ-022 All non-control ops SHALL drive is_jump_chosen=0 and next_pc=pc+4.
REQ-023 MUL with MUL_EN=1: the FSM SHALL enter S_MUL. Shift-add runs one bit per cycle for XLEN cycles and produces the low XLEN bits of the product. Output loads on the XLEN-th edge after accept, so out_valid rises XLEN+1 cycles after accept.
REQ-024 S_HOLD: out_valid=1 and all outputs SHALL stay stable until out_ready=1. With out_ready=1 and no new accept, go to S_IDLE and clear out_valid. With out_ready=1 and a simultaneous accept, load the new op with no bubble.
REQ-025 flush SHALL have priority over every other event: go to S_IDLE, clear out_valid, abort the multiplier, and accept nothing in that cycle (in_ready=0 while flush=1).
REQ-026 Back-pressure SHALL NOT drop or corrupt a held result, for any number of stalled cycles.

Reset
REQ-027 rstn=0 SHALL asynchronously force S_IDLE, out_valid=0, busy=0, result=0, is_jump_chosen=0, next_pc=0, and clear the multiplier counter and accumulator. This SHALL hold even mid-multiply.
REQ-028 The first accept SHALL be possible on the first rising edge after rstn deasserts.

Structure
REQ-029 exec_op_t and the state enum SHALL live in the shared package def.sv, next to the instructions typedef.
REQ-030 The multiply path SHALL be the sub-module mul_iter, with ports: start, a, b, abort, done, product. The FSM, compare and adder logic stay in exec_mc.

Verification
REQ-031 ADD rs1=5, rs2=7, out_ready=1 -> out_valid one cycle later, result=12, is_jump_chosen=0, next_pc=pc+4.
REQ-032 BLT pc=0x100, rs1=0xFFFFFFFF, rs2=1, imm=0x20 -> is_jump_chosen=1, next_pc=0x120. Same with BGE -> 0, next_pc=0x104.
REQ-033 JALR rs1=0x1001, imm=0x4, pc=0x40 -> next_pc=0x1004, result=0x44.
REQ-034 MUL 0xFFFF x 0x10001 -> busy for 32 cycles, out_valid at accept+33, result=0xFFFFFFFF. flush at cycle 10 of a second MUL -> no out_valid, in_ready=1 next cycle.
REQ-035 ADD result with out_ready=0 for 5 cycles -> result stable, in_ready=0. Then out_ready=1 with SUB 3-5 presented -> next cycle result=0xFFFFFFFE, out_valid continuous.
REQ-036 rstn pulsed low during S_MUL -> outputs cleared immediately; ADD issued after release completes correctly.
